// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a registered borrow compute a - b - bin, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic x_bit, y_bit, d_bit, br_nxt;

  // Full-subtractor cell on the current operand LSBs.
  always_comb begin
    x_bit  = a_q[0];
    y_bit  = b_q[0];
    d_bit  = x_bit ^ y_bit ^ br_q;
    br_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          // br_q here is the borrow entering the MSB cell.
          ovf_d   = br_q ^ br_nxt;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=4 vector table, handshake corner sequences, WIDTH=8 sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

`ifdef SERIAL_SUB_OVF_EN
  logic       ovf4, ovf8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic op4(input logic [3:0] ai, input logic [3:0] bi, input logic bini,
                     input logic [3:0] ed, input logic eb, input logic eo, input string nm);
    @(negedge clk);
    a4 = ai; b4 = bi; bin4 = bini; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = ~ai; b4 = ~bi; bin4 = ~bini;
    chk({nm, "_busy_E0"}, 32'(busy4), 1);
    chk({nm, "_done_E0"}, 32'(done4), 0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk({nm, "_busy_run"}, 32'(busy4), 1);
      chk({nm, "_done_run"}, 32'(done4), 0);
    end
    @(posedge clk); #1;
    chk({nm, "_done_E4"}, 32'(done4), 1);
    chk({nm, "_busy_E4"}, 32'(busy4), 0);
    chk({nm, "_diff"}, 32'(diff4), 32'(ed));
    chk({nm, "_bout"}, 32'(bout4), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf4), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation in %s", nm);
`endif
    @(posedge clk); #1;
    chk({nm, "_done_E5"}, 32'(done4), 0);
    chk({nm, "_diff_hold"}, 32'(diff4), 32'(ed));
  endtask

  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic bini);
    logic [8:0] expv;
    int         cyc;
    int         sr;
    expv = {1'b0, ai} - {1'b0, bi} - 9'(bini);
    sr   = int'($signed(ai)) - int'($signed(bi)) - int'(bini);
    @(negedge clk);
    a8 = ai; b8 = bi; bin8 = bini; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w8_latency", 32'(cyc), 8);
    chk("w8_result", 32'({bout8, diff8}), 32'(expv));
`ifdef SERIAL_SUB_OVF_EN
    chk("w8_ovf", 32'(ovf8), (sr > 127 || sr < -128) ? 1 : 0);
`else
    if (sr > 1000) $display("note: impossible signed result %0d", sr);
`endif
  endtask

  initial begin
    bit seen_done;

    vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1};
    vecs[1] = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
    vecs[3] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
    vecs[4] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0, 1'b0};
    vecs[5] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    vecs[6] = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
    vecs[7] = '{4'd0,  4'd8,  1'b0, 4'd8,  1'b1, 1'b1};
    vecs[8] = '{4'd12, 4'd4,  1'b1, 4'd7,  1'b0, 1'b1};
    vecs[9] = '{4'd6,  4'd2,  1'b1, 4'd3,  1'b0, 1'b0};

    #1;
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_diff", 32'(diff4), 0);
    chk("rst_bout", 32'(bout4), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      op4(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout,
          vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // start held through RUN with new operands, then accepted in the DONE cycle
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'd15; b4 = 4'd1;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk("hold_busy_run", 32'(busy4), 1);
    end
    @(posedge clk); #1;
    chk("hold_done", 32'(done4), 1);
    chk("hold_diff", 32'(diff4), 6);
    chk("hold_bout", 32'(bout4), 0);
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("b2b_busy", 32'(busy4), 1);
    chk("b2b_done", 32'(done4), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("b2b_no_partial", 32'(diff4), 6);
      chk("b2b_done_low", 32'(done4), 0);
    end
    @(posedge clk); #1;
    chk("b2b_done2", 32'(done4), 1);
    chk("b2b_diff2", 32'(diff4), 14);
    chk("b2b_bout2", 32'(bout4), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("b2b_ovf2", 32'(ovf4), 0);
`endif
    @(posedge clk); #1;

    // asynchronous reset between E2 and E3 of a run
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd9; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy4), 0);
    chk("mid_rst_done", 32'(done4), 0);
    chk("mid_rst_diff", 32'(diff4), 0);
    chk("mid_rst_bout", 32'(bout4), 0);
    #1 rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) seen_done = 1'b1;
    end
    chk("mid_rst_no_done", 32'(seen_done), 0);
    op4(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1, "after_rst");

    op8(8'd0, 8'd255, 1'b1);
    op8(8'd255, 8'd0, 1'b0);
    op8(8'd128, 8'd1, 1'b0);
    for (int i = 0; i < 20; i++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
